mask_streamer: RTL and testbench

Downstream of the pattern loader: drains the 256-bit pattern FIFO that the loader fills and serializes each word into OUT_W-bit slices for the imager mask shift chain. After every WORDS_PER_PAT words (one full sub-frame mask) it pulses `mask_load` so the imager latches the mask. It repeats this for `num_pat` patterns per `start` command, then reports `done`.

---
 rtl/mask_streamer_if.sv | 26 ++
 rtl/mask_streamer.sv | 174 +++++++++++++++++
 tb/tb_mask_streamer.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mask_streamer_if.sv
// Pattern-FIFO read port and imager mask shift-chain port of the mask streamer.
interface mask_streamer_if #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned OUT_W  = 32
);
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_valid;
  logic              fifo_rd_en;
  logic [OUT_W-1:0]  mask_data;
  logic              mask_valid;
  logic              mask_ready;
  logic              mask_load;

  // Streamer side: reads the FIFO, drives the imager.
  modport master (
    input  fifo_dout, fifo_empty, fifo_valid, mask_ready,
    output fifo_rd_en, mask_data, mask_valid, mask_load
  );

  // FIFO / imager side.
  modport slave (
    output fifo_dout, fifo_empty, fifo_valid, mask_ready,
    input  fifo_rd_en, mask_data, mask_valid, mask_load
  );
endinterface

// File: rtl/mask_streamer.sv
// Drains the pattern FIFO one word at a time, serializes each word LSB slice first
// into the imager mask chain and pulses mask_load after every full pattern.
module mask_streamer #(
  parameter int unsigned DATA_W        = 256,
  parameter int unsigned OUT_W         = 32,
  parameter int unsigned WORDS_PER_PAT = 640
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [31:0]     num_pat,
  mask_streamer_if.master bus,
  output logic            busy,
  output logic            done,
  output logic [31:0]     pat_cnt
);

  localparam int unsigned CNT_W   = 32;
  localparam int unsigned SLICES  = DATA_W / OUT_W;
  localparam int unsigned SLICE_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int unsigned WORD_W  = (WORDS_PER_PAT > 1) ? $clog2(WORDS_PER_PAT) : 1;

  localparam logic [SLICE_W-1:0] LAST_SLICE = SLICE_W'(SLICES - 1);
  localparam logic [WORD_W-1:0]  LAST_WORD  = WORD_W'(WORDS_PER_PAT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_LOAD  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]         state_q,     state_d;
  logic [CNT_W-1:0]   num_pat_q,   num_pat_d;
  logic [CNT_W-1:0]   pat_cnt_q,   pat_cnt_d;
  logic [WORD_W-1:0]  word_cnt_q,  word_cnt_d;
  logic [SLICE_W-1:0] slice_cnt_q, slice_cnt_d;
  logic [DATA_W-1:0]  shift_q,     shift_d;
  logic               rd_en_q,     rd_en_d;
  logic               valid_q,     valid_d;
  logic               load_q,      load_d;
  logic               busy_q,      busy_d;
  logic               done_q,      done_d;

  assign bus.fifo_rd_en = rd_en_q;
  assign bus.mask_valid = valid_q;
  assign bus.mask_load  = load_q;
  assign bus.mask_data  = shift_q[OUT_W-1:0];
  assign busy           = busy_q;
  assign done           = done_q;
  assign pat_cnt        = pat_cnt_q;

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      num_pat_q   <= '0;
      pat_cnt_q   <= '0;
      word_cnt_q  <= '0;
      slice_cnt_q <= '0;
      shift_q     <= '0;
      rd_en_q     <= 1'b0;
      valid_q     <= 1'b0;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_pat_q   <= num_pat_d;
      pat_cnt_q   <= pat_cnt_d;
      word_cnt_q  <= word_cnt_d;
      slice_cnt_q <= slice_cnt_d;
      shift_q     <= shift_d;
      rd_en_q     <= rd_en_d;
      valid_q     <= valid_d;
      load_q      <= load_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next state and next values of every register; pulses default low.
  always_comb begin
    state_d     = state_q;
    num_pat_d   = num_pat_q;
    pat_cnt_d   = pat_cnt_q;
    word_cnt_d  = word_cnt_q;
    slice_cnt_d = slice_cnt_q;
    shift_d     = shift_q;
    rd_en_d     = 1'b0;
    valid_d     = valid_q;
    load_d      = 1'b0;
    done_d      = 1'b0;
    busy_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          num_pat_d  = num_pat;
          pat_cnt_d  = '0;
          word_cnt_d = '0;
          if (num_pat != '0) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_FETCH: begin
        if (!bus.fifo_empty) begin
          rd_en_d = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A single read is outstanding; its data is only accepted here.
        if (bus.fifo_valid) begin
          shift_d     = bus.fifo_dout;
          slice_cnt_d = '0;
          valid_d     = 1'b1;
          state_d     = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (valid_q && bus.mask_ready) begin
          shift_d     = shift_q >> OUT_W;
          slice_cnt_d = slice_cnt_q + 1'b1;
          if (slice_cnt_q == LAST_SLICE) begin
            valid_d = 1'b0;
            if (word_cnt_q == LAST_WORD) begin
              word_cnt_d = '0;
              pat_cnt_d  = pat_cnt_q + 32'd1;
              load_d     = 1'b1;
              state_d    = S_LOAD;
            end else begin
              word_cnt_d = word_cnt_q + 1'b1;
              state_d    = S_FETCH;
            end
          end
        end
      end
      S_LOAD: begin
        // pat_cnt already holds the incremented count; equality only, never num_pat-1.
        if (pat_cnt_q == num_pat_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      pat_cnt_d = pat_cnt_q;
      rd_en_d   = 1'b0;
      valid_d   = 1'b0;
      load_d    = 1'b0;
      done_d    = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_mask_streamer.sv
// Scoreboard bench for mask_streamer: FIFO model, imager-side monitor and
// a slice-level reference derived from the words pushed into the FIFO.
module tb_mask_streamer;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned OUT_W      = 16;
  localparam int unsigned WPP        = 4;
  localparam int unsigned SLICES     = DATA_W / OUT_W;
  localparam int unsigned PAT_SLICES = SLICES * WPP;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [31:0] num_pat;
  logic        busy;
  logic        done;
  logic [31:0] pat_cnt;

  mask_streamer_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

  mask_streamer #(
    .DATA_W(DATA_W), .OUT_W(OUT_W), .WORDS_PER_PAT(WPP)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .num_pat(num_pat),
    .bus(bus), .busy(busy), .done(done), .pat_cnt(pat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] pend_w[$];
  int                pend_t[$];
  logic [OUT_W-1:0]  exp_q[$];
  int                fifo_lat   = 1;
  int                ready_mode = 0;

  int load_cnt = 0, done_cnt = 0, rd_cnt = 0, acc_total = 0, acc_since_load = 0;
  int mcyc = 0, fcyc = 0, load_cyc = 0, done_cyc = 0;
  int base_load, base_done, base_rd;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // FIFO model: a read seen in cycle c returns data fifo_lat cycles later.
  always @(negedge clk) begin
    fcyc++;
    bus.fifo_valid = 1'b0;
    if (rst) begin
      pend_w.delete();
      pend_t.delete();
    end else begin
      if (bus.fifo_rd_en && fifo_q.size() > 0) begin
        pend_w.push_back(fifo_q.pop_front());
        pend_t.push_back(fcyc + fifo_lat);
      end
      if (pend_t.size() > 0 && pend_t[0] <= fcyc) begin
        bus.fifo_valid = 1'b1;
        bus.fifo_dout  = pend_w.pop_front();
        void'(pend_t.pop_front());
      end
    end
    bus.fifo_empty = (fifo_q.size() == 0);
  end

  // Imager ready pattern.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       bus.mask_ready = 1'b1;
      1:       bus.mask_ready = ~bus.mask_ready;
      2:       bus.mask_ready = 1'($urandom_range(0, 1));
      default: bus.mask_ready = 1'b0;
    endcase
  end

  // Monitor: scoreboard pops on every accepted slice, plus protocol checks.
  logic             prev_valid = 1'b0, prev_ready = 1'b0, prev_abort = 1'b0, prev_rd = 1'b0;
  logic [OUT_W-1:0] prev_data = '0;
  always @(negedge clk) begin
    mcyc++;
    if (rst) begin
      prev_valid = 1'b0;
      prev_rd    = 1'b0;
    end else begin
      if (prev_valid && !prev_ready && !prev_abort) begin
        check("stall_valid_held", 64'(bus.mask_valid), 64'd1);
        check("stall_data_stable", 64'(bus.mask_data), 64'(prev_data));
      end
      if (prev_rd) check("rd_en_single_cycle", 64'(bus.fifo_rd_en), 64'd0);
      if (bus.fifo_rd_en) rd_cnt++;
      if (bus.mask_load) begin
        load_cnt++;
        load_cyc = mcyc;
        check("slices_per_pattern", 64'(acc_since_load), 64'(PAT_SLICES));
        check("valid_low_in_load", 64'(bus.mask_valid), 64'd0);
        acc_since_load = 0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = mcyc;
      end
      if (bus.mask_valid && bus.mask_ready && !abort) begin
        acc_total++;
        acc_since_load++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL slice_unexpected: got %0h, expected no slice", bus.mask_data);
        end else begin
          check("slice_data", 64'(bus.mask_data), 64'(exp_q.pop_front()));
        end
      end
      prev_valid = bus.mask_valid;
      prev_ready = bus.mask_ready;
      prev_data  = bus.mask_data;
      prev_abort = abort;
      prev_rd    = bus.fifo_rd_en;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push n words into the FIFO; when expected, queue their slices LSB first.
  task automatic load_words(input int n, input logic [DATA_W-1:0] first,
                            input bit use_first, input bit expect_out);
    logic [DATA_W-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = {$urandom, $urandom};
      if (use_first && i == 0) w = first;
      fifo_q.push_back(w);
      if (expect_out)
        for (int s = 0; s < int'(SLICES); s++) exp_q.push_back(OUT_W'(w >> (s * OUT_W)));
    end
  endtask

  task automatic begin_cmd(input logic [31:0] n);
    base_load      = load_cnt;
    base_done      = done_cnt;
    base_rd        = rd_cnt;
    acc_since_load = 0;
    num_pat = n;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_done(input string name, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: done not seen, expected within %0d cycles", name, budget);
    end
  endtask

  task automatic end_cmd(input string name, input int n);
    bit ok;
    wait_done(name, 300 * n + 50, ok);
    if (ok) check({name, "_pat_cnt"}, 64'(pat_cnt), 64'(n));
    tick();
    check({name, "_done_pulse_width"}, 64'(done), 64'd0);
    check({name, "_idle_after_done"}, 64'(busy), 64'd0);
    check({name, "_done_count"}, 64'(done_cnt - base_done), 64'd1);
    check({name, "_load_count"}, 64'(load_cnt - base_load), 64'(n));
    check({name, "_read_count"}, 64'(rd_cnt - base_rd), 64'(n * int'(WPP)));
    check({name, "_scoreboard_drained"}, 64'(exp_q.size()), 64'd0);
    if (n > 0) check({name, "_done_after_load"}, 64'(done_cyc), 64'(load_cyc + 1));
  endtask

  task automatic run_cmd(input string name, input int n, input logic [DATA_W-1:0] first,
                         input bit use_first);
    load_words(n * int'(WPP), first, use_first, 1'b1);
    begin_cmd(32'(n));
    if (n > 0) begin
      tick();
      check({name, "_start_to_rd"}, 64'(bus.fifo_rd_en), 64'd1);
    end
    end_cmd(name, n);
  endtask

  task automatic wait_cond_acc(input int target, input int budget);
    int i;
    for (i = 0; i < budget && acc_total < target; i++) tick();
    if (acc_total < target) begin
      checks++;
      errors++;
      $display("FAIL wait_slices_timeout: got %0d slices, expected %0d", acc_total, target);
    end
  endtask

  initial begin
    bit ok;
    int d0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; num_pat = '0;
    bus.fifo_dout = '0; bus.fifo_valid = 1'b0; bus.fifo_empty = 1'b1; bus.mask_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    check("rst_mask_valid", 64'(bus.mask_valid), 64'd0);
    check("rst_mask_data", 64'(bus.mask_data), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_pat_cnt", 64'(pat_cnt), 64'd0);
    rst = 1'b0;
    tick();

    ready_mode = 0;
    run_cmd("single", 1, 64'h0004_0003_0002_0001, 1'b1);

    ready_mode = 1;
    run_cmd("backpressure", 2, '0, 1'b0);

    // FIFO runs dry after two words of a pattern.
    ready_mode = 0;
    load_words(2, '0, 1'b0, 1'b1);
    begin_cmd(32'd1);
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) tick();
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      check("underflow_rd_en", 64'(bus.fifo_rd_en), 64'd0);
      check("underflow_mask_valid", 64'(bus.mask_valid), 64'd0);
      tick();
    end
    load_words(2, '0, 1'b0, 1'b1);
    end_cmd("underflow", 1);

    ready_mode = 2;
    run_cmd("multi", 3, '0, 1'b0);

    ready_mode = 0;
    run_cmd("zero", 0, '0, 1'b0);

    // Start while busy is ignored.
    load_words(2 * int'(WPP), '0, 1'b0, 1'b1);
    begin_cmd(32'd2);
    repeat (5) tick();
    num_pat = 32'd7;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    end_cmd("start_busy", 2);

    // Abort while a slice is stalled in SHIFT.
    ready_mode = 3;
    d0 = done_cnt;
    load_words(int'(WPP), '0, 1'b0, 1'b0);
    begin_cmd(32'd1);
    for (int i = 0; i < 50 && !bus.mask_valid; i++) tick();
    check("abort_reached_shift", 64'(bus.mask_valid), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_mask_valid", 64'(bus.mask_valid), 64'd0);
    check("abort_pat_cnt", 64'(pat_cnt), 64'd0);
    repeat (3) tick();
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    fifo_q.delete();

    // Abort with a read in flight; the late word must not be used.
    ready_mode = 0;
    fifo_lat   = 4;
    d0 = done_cnt;
    load_words(int'(WPP), '0, 1'b0, 1'b0);
    begin_cmd(32'd1);
    tick();
    check("inflight_rd_en", 64'(bus.fifo_rd_en), 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("inflight_abort_busy", 64'(busy), 64'd0);
    repeat (6) tick();
    check("late_valid_ignored", 64'(bus.mask_valid), 64'd0);
    check("late_valid_idle", 64'(busy), 64'd0);
    check("inflight_no_done", 64'(done_cnt - d0), 64'd0);
    fifo_q.delete();
    fifo_lat = 1;
    run_cmd("after_abort", 1, '0, 1'b0);

    // Asynchronous reset in the middle of a word.
    ready_mode = 1;
    load_words(2 * int'(WPP), '0, 1'b0, 1'b1);
    begin_cmd(32'd2);
    wait_cond_acc(acc_total + 5, 200);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_rd_en", 64'(bus.fifo_rd_en), 64'd0);
    check("arst_mask_valid", 64'(bus.mask_valid), 64'd0);
    check("arst_mask_data", 64'(bus.mask_data), 64'd0);
    check("arst_mask_load", 64'(bus.mask_load), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_pat_cnt", 64'(pat_cnt), 64'd0);
    fifo_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    ready_mode = 0;
    run_cmd("post_reset", 1, 64'h0004_0003_0002_0001, 1'b1);

    for (int k = 0; k < 4; k++) begin
      ready_mode = int'($urandom_range(0, 2));
      fifo_lat   = int'($urandom_range(1, 3));
      run_cmd("random", int'($urandom_range(1, 3)), '0, 1'b0);
    end

    ok = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 2000000");
    $fatal(1, "watchdog expired");
  end

endmodule
